// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder: decodes 0xAA addr data (write) and 0xBB addr (read) byte frames into register-file strobes.
// Define RX_CMD_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle cycles.
module rx_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  cmd_error,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d, rd_q, rd_d, err_q, err_d, busy_q;
  logic                  to_expire;

  if (ADDR_WIDTH > DATA_WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("rx_cmd_decoder: invalid parameters");
  end

`ifdef RX_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // a byte arriving on the expiry cycle wins, so rx_valid masks the abort
  assign to_expire = state_q != IDLE && !rx_valid && cnt_q == LAST;
  assign cnt_d = (state_q == IDLE || rx_valid || to_expire) ? '0 :
                 (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign to_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    err_d   = to_expire;
    if (to_expire) state_d = IDLE;
    else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          state_d = (rx_data == DATA_WIDTH'(8'hAA)) ? WR_ADDR :
                    (rx_data == DATA_WIDTH'(8'hBB)) ? RD_ADDR : IDLE;
          err_d   = rx_data != DATA_WIDTH'(8'hAA) && rx_data != DATA_WIDTH'(8'hBB);
        end
        WR_ADDR: begin
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
        WR_DATA: begin
          wdata_d = rx_data;
          wr_d    = 1'b1;
          state_d = IDLE;
        end
        default: begin
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          rd_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      busy_q  <= state_d != IDLE;
    end
  end

  assign rf_wr_en   = wr_q;
  assign rf_rd_en   = rd_q;
  assign rf_addr    = addr_q;
  assign rf_wr_data = wdata_q;
  assign cmd_error  = err_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_rx_cmd_decoder.sv
// tb_rx_cmd_decoder: directed frames plus random byte streams checked against a frame-level reference model.
module tb_rx_cmd_decoder;
  localparam int T = 16;
  logic       clk = 1'b0, rst = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rf_wr_en, rf_rd_en, cmd_error, busy;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  int         checks = 0, failures = 0;
  int         n_wr = 0, n_rd = 0, n_err = 0;
  logic [7:0] fr[$];
  int         gap = 0;
  logic       e_wr = 0, e_rd = 0, e_err = 0;
  logic [3:0] e_addr = '0;
  logic [7:0] e_wdata = '0;

  always #5 clk = ~clk;

  rx_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data), .cmd_error(cmd_error), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // frame collector: bytes of the partial command are held in fr
  task automatic model(input logic r, input logic v, input logic [7:0] d);
    e_wr = 0; e_rd = 0; e_err = 0;
    if (!r) begin
      fr.delete(); gap = 0; e_addr = '0; e_wdata = '0;
    end else if (v) begin
      gap = 0;
      if (fr.size() == 0) begin
        if (d == 8'hAA || d == 8'hBB) fr.push_back(d);
        else e_err = 1;
      end else if (fr[0] == 8'hBB) begin
        e_addr = d[3:0]; e_rd = 1; fr.delete();
      end else if (fr.size() == 1) begin
        e_addr = d[3:0]; fr.push_back(d);
      end else begin
        e_wdata = d; e_wr = 1; fr.delete();
      end
    end else if (fr.size() != 0) begin
`ifdef RX_CMD_TIMEOUT_EN
      gap++;
      if (gap == T) begin
        e_err = 1; fr.delete(); gap = 0;
      end
`endif
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst = r; rx_valid = v; rx_data = d;
    @(posedge clk);
    model(r, v, d);
    #1;
    chk("wr_en", rf_wr_en, e_wr);
    chk("rd_en", rf_rd_en, e_rd);
    chk("cmd_error", cmd_error, e_err);
    chk("busy", busy, fr.size() != 0);
    chk("addr", rf_addr, e_addr);
    chk("wr_data", rf_wr_data, e_wdata);
    chk("excl", 32'(rf_wr_en) + 32'(rf_rd_en) + 32'(cmd_error) <= 1, 1);
    n_wr += int'(rf_wr_en); n_rd += int'(rf_rd_en); n_err += int'(cmd_error);
  endtask

  task automatic send(input logic [7:0] d);
    step(1, 1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 8'h00);
  endtask

  task automatic clr();
    n_wr = 0; n_rd = 0; n_err = 0;
  endtask

  initial begin
    step(0, 0, 8'h00);
    step(0, 1, 8'hAA);
    chk("rst_busy", busy, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_wdata", rf_wr_data, 0);
    clr();
    send(8'hAA); idle(3); send(8'h03); idle(3); send(8'h5C);
    chk("w_now", rf_wr_en, 1);
    chk("w_addr", rf_addr, 3);
    chk("w_data", rf_wr_data, 8'h5C);
    idle(1);
    chk("w_once", n_wr, 1);
    clr();
    send(8'hBB); send(8'hF7);
    chk("r_now", rf_rd_en, 1);
    chk("r_addr", rf_addr, 7);
    idle(1);
    chk("r_once", n_rd, 1);
    chk("r_busy", busy, 0);
    clr();
    send(8'h12);
    chk("bad_err", cmd_error, 1);
    idle(2);
    chk("bad_once", n_err, 1);
    chk("bad_nostb", n_wr + n_rd, 0);
    clr();
    send(8'hAA); send(8'h01); step(0, 1, 8'hAA); send(8'h99);
    chk("abort_err", cmd_error, 1);
    chk("abort_addr", rf_addr, 0);
    idle(2);
    chk("abort_nowr", n_wr, 0);
    chk("abort_errs", n_err, 1);
    clr();
`ifdef RX_CMD_TIMEOUT_EN
    send(8'hAA); idle(T);
    chk("to_err", n_err, 1);
    chk("to_busy", busy, 0);
    send(8'hBB); send(8'h02);
    chk("to_rd", rf_rd_en, 1);
    chk("to_addr", rf_addr, 2);
`else
    send(8'hAA); idle(5000);
    chk("wait_err", n_err, 0);
    chk("wait_busy", busy, 1);
    send(8'hBB); send(8'h02);
    chk("wait_wr", rf_wr_en, 1);
    chk("wait_addr", rf_addr, 4'hB);
`endif
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [7:0] d;
      sel = int'($urandom_range(0, 3));
      d = (sel == 0) ? 8'hAA : (sel == 1) ? 8'hBB : 8'($urandom);
      if ($urandom_range(0, 29) == 0) idle(int'($urandom_range(10, 24)));
      step($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, d);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rx_cmd_decoder.md
RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the received byte width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, giving the register-file address width (ADDR_WIDTH <= DATA_WIDTH).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the inter-byte timeout in clk cycles (see REQ-021).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge clocked.
REQ-005 The block SHALL have port rst, input, 1, the synchronous active-low reset.
REQ-006 The block SHALL have port rx_data, input, DATA_WIDTH, the synchronized received byte, valid only when rx_valid=1.
REQ-007 The block SHALL have port rx_valid, input, 1, a single-cycle strobe qualifying rx_data, one byte per strobe.
REQ-008 The block SHALL have port rf_wr_en, output, 1, a one-cycle register-file write strobe.
REQ-009 The block SHALL have port rf_rd_en, output, 1, a one-cycle register-file read strobe.
REQ-010 The block SHALL have port rf_addr, output, ADDR_WIDTH, the register-file address, held between commands.
REQ-011 The block SHALL have port rf_wr_data, output, DATA_WIDTH, the write data, held between commands.
REQ-012 The block SHALL have port cmd_error, output, 1, a one-cycle strobe flagging a bad opcode or an aborted frame.
REQ-013 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, WR_ADDR, WR_DATA and RD_ADDR, and SHALL change state only on cycles with rx_valid=1, except for the change in REQ-021.
REQ-015 In IDLE, rx_data=0xAA SHALL move the FSM to WR_ADDR, 0xBB SHALL move it to RD_ADDR, and any other value SHALL pulse cmd_error on the next cycle while the FSM stays in IDLE.
REQ-016 In WR_ADDR, the block SHALL latch rx_data[ADDR_WIDTH-1:0] into rf_addr, ignore the upper bits, and move to WR_DATA.
REQ-017 In WR_DATA, the block SHALL latch rx_data into rf_wr_data, assert rf_wr_en for exactly one cycle on the cycle after the rx_valid sample, and move to IDLE.
REQ-018 In RD_ADDR, the block SHALL latch the address into rf_addr, assert rf_rd_en for exactly one cycle on the cycle after the sample, and move to IDLE.
REQ-019 All outputs SHALL be registered, with strobe latency of 1 cycle from the final byte's rx_valid, and rf_wr_en, rf_rd_en and cmd_error SHALL never be high together.
REQ-020 Back-to-back rx_valid on consecutive cycles SHALL be accepted with no byte dropped, and a new opcode SHALL be accepted in the same cycle in which the previous command's strobe is high.
REQ-021 With the timeout feature enabled, if the FSM is outside IDLE and TIMEOUT_CYCLES cycles elapse without rx_valid, the FSM SHALL return to IDLE and pulse cmd_error once, and rf_addr and rf_wr_data SHALL keep their previous values.
REQ-022 The timeout counter SHALL clear on every rx_valid and in IDLE, and saturate without wrap-around; rx_valid arriving in the same cycle as expiry SHALL win, so that the byte is processed and no error is raised.

Reset
REQ-023 When rst=0 at a rising clk edge, the FSM SHALL go to IDLE and rf_wr_en, rf_rd_en, cmd_error and busy SHALL become 0, with rf_addr=0, rf_wr_data=0 and the timeout counter at 0.
REQ-024 A reset asserted mid-frame SHALL discard the partial command with no strobe and no cmd_error, and rx_valid SHALL be ignored while rst=0.

Configuration
REQ-025 The macro RX_CMD_TIMEOUT_EN SHALL compile in the timeout counter and REQ-021/REQ-022.
REQ-026 Without RX_CMD_TIMEOUT_EN, no counter SHALL exist, a partial frame SHALL wait indefinitely, and cmd_error SHALL arise only from a bad opcode.

Verification
REQ-027 The bench SHALL drive bytes 0xAA, 0x03, 0x5C with gaps of 3 cycles and require rf_wr_en=1 for exactly 1 cycle, one cycle after the 0x5C strobe, with rf_addr=3 and rf_wr_data=0x5C.
REQ-028 The bench SHALL drive bytes 0xBB, 0xF7 on consecutive cycles and require rf_rd_en=1 for 1 cycle with rf_addr=7 (upper bits dropped) and busy=0 afterwards.
REQ-029 The bench SHALL drive byte 0x12 in IDLE and require cmd_error=1 for 1 cycle, busy=0 throughout, and no rf strobes.
REQ-030 The bench SHALL drive 0xAA, 0x01, then assert rst=0 for 1 cycle, then drive 0x99, and require no rf_wr_en, cmd_error pulsed for 0x99 only, and rf_addr=0.
REQ-031 With RX_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, the bench SHALL drive 0xAA and then stay idle for 16 cycles, and require one cmd_error, busy=0, and a following 0xBB, 0x02 yielding rf_rd_en with rf_addr=2.
REQ-032 Without RX_CMD_TIMEOUT_EN, the bench SHALL repeat REQ-031 with a 5000-cycle gap and require busy=1 throughout and no cmd_error.
